// File: rtl/dma_axi_simple_pkg.sv
// Shared constants for the simple AXI DMA CSR block: register offsets, ID words,
// CONTROL/STATUS field positions and the sequencer state encoding.
package dma_axi_simple_pkg;

    localparam logic [7:0] OFF_NAME    = 8'h00;
    localparam logic [7:0] OFF_VERSION = 8'h04;
    localparam logic [7:0] OFF_CONTROL = 8'h10;
    localparam logic [7:0] OFF_STATUS  = 8'h14;
    localparam logic [7:0] OFF_SRC     = 8'h18;
    localparam logic [7:0] OFF_DST     = 8'h1C;
    localparam logic [7:0] OFF_LEN     = 8'h20;
    localparam logic [7:0] OFF_GO      = 8'h24;

    localparam logic [31:0] DMA_NAME    = 32'h444D_4120;
    localparam logic [31:0] DMA_VERSION = 32'h2015_0712;

    localparam int CTRL_EN_BIT  = 31;
    localparam int CTRL_IE_BIT  = 1;
    localparam int CTRL_IP_BIT  = 0;
    localparam int GO_START_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_axi_simple_csr_fsm.sv
// GO/BUSY/DONE sequencer for the simple AXI DMA core, plus the completion
// pending flag (IP) with set-over-clear priority.
module dma_axi_simple_csr_fsm
    import dma_axi_simple_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       en_d,
    input  logic       go_req,
    input  logic       dma_busy,
    input  logic       dma_done,
    input  logic       ip_clr,
    output dma_state_e state,
    output logic       dma_go,
    output logic       ip_q,
    output logic       ip_d
);

    dma_state_e state_q;
    dma_state_e state_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            ip_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
        end
    end

    // Abort (EN dropping) overrides everything and leaves IP alone; a completion
    // sets IP even if software is clearing it in the same cycle.
    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        if (ip_clr) begin
            ip_d = 1'b0;
        end
        if (!en_d) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_req) begin
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (dma_busy) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!dma_busy && dma_done) begin
                        state_d = ST_IDLE;
                        ip_d    = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign state  = state_q;
    assign dma_go = (state_q == ST_START);

endmodule

// File: rtl/dma_axi_simple_csr.sv
// APB3 register block programming the simple AXI DMA core.
// Optional interrupt output enabled by defining DMA_AXI_SIMPLE_CSR_IRQ_EN.
module dma_axi_simple_csr
    import dma_axi_simple_pkg::*;
#(
    parameter int APB_WIDTH_AD = 32,
    parameter int APB_WIDTH_DA = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [APB_WIDTH_AD-1:0] PADDR,
    input  logic [APB_WIDTH_DA-1:0] PWDATA,
    output logic [APB_WIDTH_DA-1:0] PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    DMA_EN,
    output logic                    DMA_GO,
    input  logic                    DMA_BUSY,
    input  logic                    DMA_DONE,
    output logic [31:0]             DMA_SRC,
    output logic [31:0]             DMA_DST,
    output logic [15:0]             DMA_BNUM,
    output logic [7:0]              DMA_CHUNK
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
    ,
    output logic                    IRQ
`endif
);

    logic [3:0]              idx;
    logic                    wr_acc;
    logic                    rd_setup;
    logic                    active;
    logic                    err;
    logic                    wr_ok;
    logic                    go_req;
    logic                    ip_clr;
    logic                    ip_q;
    logic                    ip_d;
    logic                    ie_val;
    logic [APB_WIDTH_DA-1:0] rdata;
    dma_state_e              state;

    logic                    en_q,     en_d;
    logic [31:0]             src_q,    src_d;
    logic [31:0]             dst_q,    dst_d;
    logic [15:0]             bnum_q,   bnum_d;
    logic [7:0]              chunk_q,  chunk_d;
    logic [APB_WIDTH_DA-1:0] prdata_q, prdata_d;

    logic unused_paddr;
    assign unused_paddr = ^{PADDR[APB_WIDTH_AD-1:6], PADDR[1:0]};

    assign idx      = PADDR[5:2];
    assign wr_acc   = PSEL & PENABLE & PWRITE;
    assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
    assign active   = (state != ST_IDLE);

    // Transfer parameters are frozen while a transfer is in flight, and a start
    // request that cannot run is refused rather than silently ignored.
    always_comb begin
        err = 1'b0;
        if (wr_acc) begin
            if (active && (idx == OFF_SRC[5:2] || idx == OFF_DST[5:2] ||
                           idx == OFF_LEN[5:2] || idx == OFF_GO[5:2])) begin
                err = 1'b1;
            end
            if (idx == OFF_GO[5:2] && PWDATA[GO_START_BIT] &&
                (!en_q || bnum_q == 16'd0)) begin
                err = 1'b1;
            end
        end
    end

    assign wr_ok  = wr_acc & ~err;
    assign go_req = wr_ok & (idx == OFF_GO[5:2]) & PWDATA[GO_START_BIT];

`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;
    assign ie_val = ie_q;
    assign irq_d  = ip_d & ie_d;
    assign IRQ    = irq_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        ie_d = ie_q;
        if (wr_ok && idx == OFF_CONTROL[5:2]) begin
            ie_d = PWDATA[CTRL_IE_BIT];
        end
    end
`else
    assign ie_val = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            OFF_NAME[5:2]:    rdata = DMA_NAME;
            OFF_VERSION[5:2]: rdata = DMA_VERSION;
            OFF_CONTROL[5:2]: rdata = {en_q, 29'd0, ie_val, ip_q};
            OFF_STATUS[5:2]:  rdata = {29'd0, active, DMA_DONE, DMA_BUSY};
            OFF_SRC[5:2]:     rdata = src_q;
            OFF_DST[5:2]:     rdata = dst_q;
            OFF_LEN[5:2]:     rdata = {8'd0, chunk_q, bnum_q};
            OFF_GO[5:2]:      rdata = {31'd0, active};
            default:          rdata = '0;
        endcase
    end

    always_comb begin
        en_d     = en_q;
        src_d    = src_q;
        dst_d    = dst_q;
        bnum_d   = bnum_q;
        chunk_d  = chunk_q;
        prdata_d = prdata_q;
        ip_clr   = 1'b0;
        if (wr_ok) begin
            case (idx)
                OFF_CONTROL[5:2]: begin
                    en_d   = PWDATA[CTRL_EN_BIT];
                    ip_clr = PWDATA[CTRL_IP_BIT];
                end
                OFF_SRC[5:2]: src_d = PWDATA;
                OFF_DST[5:2]: dst_d = PWDATA;
                OFF_LEN[5:2]: begin
                    chunk_d = PWDATA[23:16];
                    bnum_d  = PWDATA[15:0];
                end
                default: ;
            endcase
        end
        if (rd_setup) begin
            prdata_d = rdata;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            en_q     <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            bnum_q   <= '0;
            chunk_q  <= '0;
            prdata_q <= '0;
        end else begin
            en_q     <= en_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            bnum_q   <= bnum_d;
            chunk_q  <= chunk_d;
            prdata_q <= prdata_d;
        end
    end

    dma_axi_simple_csr_fsm u_fsm (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .en_d     (en_d),
        .go_req   (go_req),
        .dma_busy (DMA_BUSY),
        .dma_done (DMA_DONE),
        .ip_clr   (ip_clr),
        .state    (state),
        .dma_go   (DMA_GO),
        .ip_q     (ip_q),
        .ip_d     (ip_d)
    );

    assign PRDATA    = prdata_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = err;
    assign DMA_EN    = en_q;
    assign DMA_SRC   = src_q;
    assign DMA_DST   = dst_q;
    assign DMA_BNUM  = bnum_q;
    assign DMA_CHUNK = chunk_q;

endmodule

// File: tb/tb_dma_axi_simple_csr.sv
// Bench for dma_axi_simple_csr: behavioural register/sequencer model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dma_axi_simple_csr;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        DMA_EN;
    logic        DMA_GO;
    logic        DMA_BUSY = 1'b0;
    logic        DMA_DONE = 1'b0;
    logic [31:0] DMA_SRC;
    logic [31:0] DMA_DST;
    logic [15:0] DMA_BNUM;
    logic [7:0]  DMA_CHUNK;
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
    logic        IRQ;
`endif

    dma_axi_simple_csr dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .DMA_EN    (DMA_EN),
        .DMA_GO    (DMA_GO),
        .DMA_BUSY  (DMA_BUSY),
        .DMA_DONE  (DMA_DONE),
        .DMA_SRC   (DMA_SRC),
        .DMA_DST   (DMA_DST),
        .DMA_BNUM  (DMA_BNUM),
        .DMA_CHUNK (DMA_CHUNK)
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
        ,
        .IRQ       (IRQ)
`endif
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en, m_ie, m_ip, m_go, m_run;
    logic [31:0] m_src, m_dst, m_prdata;
    logic [15:0] m_bnum;
    logic [7:0]  m_chunk;
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
    bit          m_irq;
`endif

    logic [7:0]  a;
    bit          acc, busy_now, e_err, wr, n_en, n_ie, n_ip, n_go, n_run;
    logic [31:0] e_rd;

    always_comb begin
        a        = {2'b00, PADDR[5:2], 2'b00};
        acc      = PSEL && PENABLE && PWRITE;
        busy_now = m_go || m_run;
        e_err    = acc && ((busy_now && (a inside {8'h18, 8'h1C, 8'h20, 8'h24})) ||
                           (a == 8'h24 && PWDATA[0] && (!m_en || m_bnum == 16'd0)));
        wr       = acc && !e_err;
        n_en     = (wr && a == 8'h10) ? PWDATA[31] : m_en;
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
        n_ie     = (wr && a == 8'h10) ? PWDATA[1] : m_ie;
`else
        n_ie     = 1'b0;
`endif
        n_ip     = (wr && a == 8'h10 && PWDATA[0]) ? 1'b0 : m_ip;
        n_go     = m_go;
        n_run    = m_run;
        if (!n_en) begin
            n_go  = 1'b0;
            n_run = 1'b0;
        end else if (m_go && DMA_BUSY) begin
            n_go  = 1'b0;
            n_run = 1'b1;
        end else if (m_run && !DMA_BUSY && DMA_DONE) begin
            n_run = 1'b0;
            n_ip  = 1'b1;
        end else if (wr && a == 8'h24 && PWDATA[0]) begin
            n_go  = 1'b1;
        end
        case (a)
            8'h00:   e_rd = 32'h444D4120;
            8'h04:   e_rd = 32'h20150712;
            8'h10:   e_rd = {m_en, 29'd0, m_ie, m_ip};
            8'h14:   e_rd = {29'd0, busy_now, DMA_DONE, DMA_BUSY};
            8'h18:   e_rd = m_src;
            8'h1C:   e_rd = m_dst;
            8'h20:   e_rd = {8'd0, m_chunk, m_bnum};
            8'h24:   e_rd = {31'd0, busy_now};
            default: e_rd = 32'd0;
        endcase
    end

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_en <= 0; m_ie <= 0; m_ip <= 0; m_go <= 0; m_run <= 0;
            m_src <= '0; m_dst <= '0; m_bnum <= '0; m_chunk <= '0; m_prdata <= '0;
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
            m_irq <= 0;
`endif
        end else begin
            m_en  <= n_en;
            m_ie  <= n_ie;
            m_ip  <= n_ip;
            m_go  <= n_go;
            m_run <= n_run;
            if (wr && a == 8'h18) m_src <= PWDATA;
            if (wr && a == 8'h1C) m_dst <= PWDATA;
            if (wr && a == 8'h20) begin
                m_bnum  <= PWDATA[15:0];
                m_chunk <= PWDATA[23:16];
            end
            if (PSEL && !PENABLE && !PWRITE) m_prdata <= e_rd;
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
            m_irq <= n_ip && n_ie;
`endif
        end
    end

    always @(negedge ACLK) begin
        if (cmp_on) begin
            chk("DMA_EN",    {31'd0, DMA_EN},  {31'd0, m_en});
            chk("DMA_GO",    {31'd0, DMA_GO},  {31'd0, m_go});
            chk("DMA_SRC",   DMA_SRC,          m_src);
            chk("DMA_DST",   DMA_DST,          m_dst);
            chk("DMA_BNUM",  {16'd0, DMA_BNUM}, {16'd0, m_bnum});
            chk("DMA_CHUNK", {24'd0, DMA_CHUNK}, {24'd0, m_chunk});
            chk("PRDATA",    PRDATA,           m_prdata);
            chk("PSLVERR",   {31'd0, PSLVERR}, {31'd0, e_err});
            chk("PREADY",    {31'd0, PREADY},  32'd1);
`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
            chk("IRQ",       {31'd0, IRQ},     {31'd0, m_irq});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic apb_wr(input logic [7:0] ad, input logic [31:0] d, output logic e);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'd0, ad}; PWDATA = d;
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        @(negedge ACLK);
        e = PSLVERR;
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] ad, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'd0, ad};
        @(posedge ACLK); #1;
        PENABLE = 1'b1;
        @(negedge ACLK);
        d = PRDATA;
        @(posedge ACLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [7:0] addr_tbl [11] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18,
                                  8'h1C, 8'h20, 8'h24, 8'h28, 8'h3C};

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d;
        cmp_on = 1'b1;
        #1 ARESETn = 1'b0;
        #2;
        chk("rst_DMA_GO",  {31'd0, DMA_GO}, 32'd0);
        chk("rst_DMA_EN",  {31'd0, DMA_EN}, 32'd0);
        chk("rst_DMA_SRC", DMA_SRC, 32'd0);
        chk("rst_PRDATA",  PRDATA, 32'd0);
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        tick(1);

        apb_rd(8'h00, d); chk("NAME", d, 32'h444D4120);
        apb_rd(8'h04, d); chk("VERSION", d, 32'h20150712);
        apb_rd(8'h14, d); chk("STATUS_rst", d, 32'd0);

        // full transfer
        apb_wr(8'h18, 32'h1000, e);      chk("wr_src_err", {31'd0, e}, 32'd0);
        apb_wr(8'h1C, 32'h2000, e);
        apb_wr(8'h20, 32'h0010_0040, e);
        apb_wr(8'h10, 32'h8000_0000, e);
        apb_wr(8'h24, 32'h1, e);         chk("go_err", {31'd0, e}, 32'd0);
        chk("go_rise", {31'd0, DMA_GO}, 32'd1);
        chk("bnum_out", {16'd0, DMA_BNUM}, 32'h40);
        chk("chunk_out", {24'd0, DMA_CHUNK}, 32'h10);
        tick(1);
        chk("go_hold", {31'd0, DMA_GO}, 32'd1);
        DMA_BUSY = 1'b1;
        tick(1);
        chk("go_drop", {31'd0, DMA_GO}, 32'd0);
        apb_rd(8'h14, d); chk("STATUS_run", d, 32'h5);

        apb_wr(8'h18, 32'hDEAD, e);      chk("busy_prot_err", {31'd0, e}, 32'd1);
        apb_rd(8'h18, d);                chk("busy_prot_src", d, 32'h1000);

        DMA_BUSY = 1'b0; DMA_DONE = 1'b1;
        tick(1);
        DMA_DONE = 1'b0;
        apb_rd(8'h10, d); chk("ip_set", d, 32'h8000_0001);
        apb_rd(8'h24, d); chk("go_rd_idle", d, 32'd0);
        apb_wr(8'h10, 32'h8000_0001, e);
        apb_rd(8'h10, d); chk("ip_w1c", d, 32'h8000_0000);

        // rejected starts
        apb_wr(8'h20, 32'h0010_0000, e); chk("len0_err", {31'd0, e}, 32'd0);
        apb_wr(8'h24, 32'h1, e);         chk("go_bnum0_err", {31'd0, e}, 32'd1);
        tick(1);
        chk("go_bnum0_go", {31'd0, DMA_GO}, 32'd0);
        apb_rd(8'h24, d); chk("go_bnum0_state", d, 32'd0);
        apb_wr(8'h20, 32'h0010_0040, e);
        apb_wr(8'h10, 32'h0, e);
        apb_wr(8'h24, 32'h1, e);         chk("go_en0_err", {31'd0, e}, 32'd1);
        chk("go_en0_go", {31'd0, DMA_GO}, 32'd0);

        // abort
        apb_wr(8'h10, 32'h8000_0000, e);
        apb_wr(8'h24, 32'h1, e);
        DMA_BUSY = 1'b1;
        tick(1);
        apb_wr(8'h10, 32'h0, e);
        chk("abort_en", {31'd0, DMA_EN}, 32'd0);
        apb_rd(8'h14, d); chk("abort_status", d, 32'h1);
        apb_rd(8'h10, d); chk("abort_ip", d, 32'd0);
        DMA_BUSY = 1'b0;
        tick(1);

`ifdef DMA_AXI_SIMPLE_CSR_IRQ_EN
        apb_wr(8'h10, 32'h8000_0002, e);
        apb_wr(8'h24, 32'h1, e);
        DMA_BUSY = 1'b1; tick(1);
        DMA_BUSY = 1'b0; DMA_DONE = 1'b1; tick(1);
        DMA_DONE = 1'b0;
        chk("irq_rise", {31'd0, IRQ}, 32'd1);
        apb_wr(8'h24, 32'h1, e);
        DMA_BUSY = 1'b1; tick(1);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWDATA = 32'h8000_0003;
        tick(1);
        PENABLE = 1'b1; DMA_BUSY = 1'b0; DMA_DONE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; DMA_DONE = 1'b0;
        apb_rd(8'h10, d); chk("set_beats_clr", d, 32'h8000_0003);
        chk("irq_keep", {31'd0, IRQ}, 32'd1);
        apb_wr(8'h10, 32'h8000_0003, e);
        chk("irq_clr", {31'd0, IRQ}, 32'd0);
        apb_rd(8'h10, d); chk("ie_rd", d, 32'h8000_0002);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            int   op;
            logic [7:0]  ad;
            logic [31:0] wd;
            DMA_BUSY = ($urandom_range(0, 1) == 1);
            DMA_DONE = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 3);
            ad = addr_tbl[$urandom_range(0, 10)];
            wd = $urandom;
            if (ad == 8'h10) wd[31] = ($urandom_range(0, 5) != 0);
            if (ad == 8'h24) wd[0]  = ($urandom_range(0, 3) != 0);
            if (ad == 8'h20 && $urandom_range(0, 5) == 0) wd[15:0] = 16'd0;
            case (op)
                0:       tick($urandom_range(1, 3));
                1, 2:    apb_wr(ad, wd, e);
                default: apb_rd(ad, d);
            endcase
        end
        DMA_BUSY = 1'b0; DMA_DONE = 1'b0;

        // reset in the middle of a transfer
        apb_wr(8'h10, 32'h8000_0000, e);
        apb_wr(8'h20, 32'h0010_0040, e);
        apb_wr(8'h18, 32'h1234, e);
        apb_wr(8'h24, 32'h1, e);
        #2 ARESETn = 1'b0;
        #1;
        chk("midrst_go",  {31'd0, DMA_GO}, 32'd0);
        chk("midrst_en",  {31'd0, DMA_EN}, 32'd0);
        chk("midrst_src", DMA_SRC, 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick(2);
        cmp_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
